mac_requant_fifo: RTL
=====================

MAC_REQUANT_FIFO -- requirements
Module: mac_requant_fifo

Interface
REQ-001 Parameter: ACC_WIDTH, default 40, accumulator width of the upstream MAC result.
REQ-002 Parameter: OUT_WIDTH, default 16, signed width of the requantized result.
REQ-003 Parameter: DEPTH, default 8, FIFO entries; power of two, minimum 2.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: acc_val  input  ACC_WIDTH  two's-complement MAC result.
REQ-007 Port: acc_valid  input  1  acc_val qualifier; no backpressure toward the MAC.
REQ-008 Port: shift_amt  input  6  right-shift amount, sampled with acc_valid.
REQ-009 Port: out_ready  input  1  downstream accept.
REQ-010 Port: clr_stats  input  1  clears drop_count and overflow.
REQ-011 Port: out_data  output  OUT_WIDTH  FIFO head, signed.
REQ-012 Port: out_sat  output  1  head entry was saturated.
REQ-013 Port: out_valid  output  1  FIFO non-empty.
REQ-014 Port: level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-015 Port: drop_count  output  16  samples dropped on a full FIFO.
REQ-016 Port: overflow  output  1  sticky; set on any drop.

Function
REQ-017 Stage 1 (registered) computes signed (acc_val + R) >>> s in ACC_WIDTH+1 bits, with s = min(shift_amt, ACC_WIDTH-1) and R = 2^(s-1) when s>0, else 0 (round half toward +inf).
REQ-018 Stage 2 (registered) saturates the stage-1 result to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and sets sat=1 exactly when clamping occurred.
REQ-019 Each stage carries a valid bit; a bubble (acc_valid=0) propagates as valid=0 with no FIFO write.
REQ-020 A valid stage-2 result pushes {sat, data} into the FIFO on the same clock edge that stage 2 would otherwise advance.
REQ-021 The FIFO is first-word-fall-through: out_data and out_sat show the head entry whenever out_valid=1.
REQ-022 Latency: with the FIFO empty, acc_valid sampled at edge k gives out_valid=1 after edge k+2, i.e. 3 cycles.
REQ-023 Pop occurs when out_valid && out_ready; on out_valid=0, out_ready is ignored.
REQ-024 A push is accepted if level<DEPTH, or if level==DEPTH with a pop in the same cycle; level is then unchanged.
REQ-025 A push that is not accepted drops the sample, increments drop_count, and sets overflow; FIFO contents and pointers are unchanged.
REQ-026 drop_count saturates at 0xFFFF.
REQ-027 clr_stats=1 zeroes drop_count and overflow, and takes priority over a drop in the same cycle; that drop is not counted.
REQ-028 Read and write pointers wrap modulo DEPTH, and level = writes accepted - pops.
REQ-029 Back-to-back acc_valid for any number of cycles is supported at one sample per cycle.

Reset
REQ-030 While rst=1 at an edge: both stage valids=0, FIFO empty (level=0, out_valid=0), drop_count=0, overflow=0.
REQ-031 out_data and out_sat read 0 during and immediately after reset; stage data registers need not be reset.
REQ-032 Reset asserted mid-stream discards all in-flight and buffered samples, with no output appearing after reset deasserts.

Verification
REQ-033 Round: acc_val=0x00_0000_0180, shift_amt=8 -> out_data=0x0002, out_sat=0, 3 cycles after input; acc_val=-384 (0xFF_FFFF_FE80), shift 8 -> 0xFFFF (-1).
REQ-034 Saturate: acc_val=0x00_0100_0000, shift 8 -> 0x7FFF, out_sat=1; acc_val=0xFF_0000_0000, shift 0 -> 0x8000, out_sat=1.
REQ-035 Fill/drop: out_ready=0, 10 consecutive valid samples with DEPTH=8 -> level=8, drop_count=2, overflow=1; then out_ready=1 -> first 8 samples emerge in order.
REQ-036 Full with simultaneous pop/push: level=8, out_ready=1, and a pushed sample in the same cycle -> level stays 8, drop_count unchanged, order preserved.
REQ-037 Clamp and clear: shift_amt=63 on acc_val=0x7F_FFFF_FFFF -> treated as shift 39 -> 0x0001; clr_stats coincident with a drop -> drop_count=0, overflow=0.
REQ-038 Reset mid-operation: rst pulsed with 2 samples in stages and 5 in the FIFO -> level=0, out_valid=0, and no outputs for 4 cycles after release.

Source files
------------

// File: rtl/mac_requant_fifo.sv
// Requantizes MAC results (round-half-up shift, saturate) into a FWFT FIFO; 3-cycle latency to out_valid.
// No backpressure toward the MAC: samples arriving at a full FIFO without a pop are dropped and counted.
module mac_requant_fifo #(
  parameter int ACC_WIDTH = 40,
  parameter int OUT_WIDTH = 16,
  parameter int DEPTH     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ACC_WIDTH-1:0]       acc_val,
  input  logic                       acc_valid,
  input  logic [5:0]                 shift_amt,
  input  logic                       out_ready,
  input  logic                       clr_stats,
  output logic [OUT_WIDTH-1:0]       out_data,
  output logic                       out_sat,
  output logic                       out_valid,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                drop_count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [5:0] S_MAX = 6'(ACC_WIDTH - 1);

  typedef struct packed {
    logic                 sat;
    logic [OUT_WIDTH-1:0] dat;
  } entry_t;

  // Stage 1: round and arithmetic shift in one extra bit so the rounding add cannot wrap
  logic [5:0]           s;
  logic [ACC_WIDTH:0]   rnd;
  logic [ACC_WIDTH:0]   sum;
  logic [ACC_WIDTH:0]   shifted;
  logic [ACC_WIDTH:0]   s1_dat;
  logic                 s1_vld;

  assign s       = (shift_amt > S_MAX) ? S_MAX : shift_amt;
  assign rnd     = (s == 6'd0) ? '0 : ({{ACC_WIDTH{1'b0}}, 1'b1} << (s - 6'd1));
  assign sum     = {acc_val[ACC_WIDTH-1], acc_val} + rnd;
  assign shifted = $signed(sum) >>> s;

  always_ff @(posedge clk) begin
    if (rst) s1_vld <= 1'b0;
    else     s1_vld <= acc_valid;
  end

  always_ff @(posedge clk) begin
    s1_dat <= shifted;
  end

  // Stage 2: result fits only when every bit above the output sign bit matches it
  logic [ACC_WIDTH-OUT_WIDTH+1:0] hi;
  logic                           clamp;
  entry_t                         s2_nxt;
  entry_t                         s2_ent;
  logic                           s2_vld;

  assign hi    = s1_dat[ACC_WIDTH:OUT_WIDTH-1];
  assign clamp = !((&hi) || (~|hi));

  always_comb begin
    s2_nxt.sat = clamp;
    s2_nxt.dat = s1_dat[OUT_WIDTH-1:0];
    if (clamp) begin
      s2_nxt.dat = s1_dat[ACC_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                     : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) s2_vld <= 1'b0;
    else     s2_vld <= s1_vld;
  end

  always_ff @(posedge clk) begin
    s2_ent <= s2_nxt;
  end

  // FIFO: a pop frees the slot in the same cycle, so full+pop still accepts the push
  entry_t         mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           full;
  logic           pop;
  logic           accept;
  logic           drop;
  logic [LW-1:0]  level_nxt;

  assign full   = (level == LW'(DEPTH));
  assign pop    = out_valid && out_ready;
  assign accept = s2_vld && (!full || pop);
  assign drop   = s2_vld && !accept;

  always_comb begin
    level_nxt = level;
    case ({accept, pop})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= s2_ent;
  end

  assign out_valid = (level != '0);
  assign out_data  = out_valid ? mem[rd_ptr].dat : '0;
  assign out_sat   = out_valid ? mem[rd_ptr].sat : 1'b0;

  // Clear wins over a coincident drop
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

endmodule
